axi_line_master: RTL and testbench

- AXI burst master that turns one cache-line request into one AXI burst on the RAM bus. Reads use AR/R; writes use AW/W/B.
- Sits directly upstream of the AXI RAM slave, between the cache refill/writeback logic and the ram_bus.
- One outstanding request at a time. The slave side has no r_ready or b_ready, so this master always accepts R and B.

---
 rtl/axi_line_master_pkg.sv | 25 ++
 rtl/axi_line_buffer.sv | 38 +++
 rtl/axi_line_master.sv | 174 +++++++++++++++++
 tb/tb_axi_line_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_line_master_pkg.sv
// Shared types and constants for the AXI cache-line burst master.
// The optional watchdog is enabled with AXI_LINE_MASTER_TIMEOUT_EN.
package axi_line_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_RESP = 3'd6
  } state_t;

  localparam logic [7:0] W_STRB_ALL = 8'hFF;
  localparam int         BEAT_W     = 64;

  // Clears the byte-offset bits that fall inside one line.
  function automatic logic [63:0] line_addr_mask(input int beats);
    int off_bits;
    off_bits = $clog2(beats * (BEAT_W / 8));
    return ~((64'd1 << off_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/axi_line_buffer.sv
// One cache line held as BEATS slots: whole-line load, single-slot write,
// single-slot read, and the full line exposed for the response.
module axi_line_buffer #(
  parameter int BEATS  = 4,
  parameter int DATA_W = 64,
  parameter int IDX_W  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [BEATS*DATA_W-1:0]   load_data,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [DATA_W-1:0]         rd_data,
  output logic [BEATS*DATA_W-1:0]   line
);

  logic [DATA_W-1:0] slot [BEATS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BEATS; i++) slot[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < BEATS; i++) slot[i] <= load_data[i*DATA_W +: DATA_W];
    end else if (wr_en) begin
      slot[wr_idx] <= wr_data;
    end
  end

  assign rd_data = slot[rd_idx];

  for (genvar g = 0; g < BEATS; g++) begin : g_line
    assign line[g*DATA_W +: DATA_W] = slot[g];
  end

endmodule

// File: rtl/axi_line_master.sv
// Turns one cache-line request into one AXI read or write burst.
// Define AXI_LINE_MASTER_TIMEOUT_EN to add the stuck-burst watchdog.
module axi_line_master
  import axi_line_master_pkg::*;
#(
  parameter int BEATS          = 4,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = BEAT_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wen,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [BEATS*DATA_W-1:0]   req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [BEATS*DATA_W-1:0]   resp_rdata,
  output logic                      resp_err,
  output logic                      ar_valid,
  input  logic                      ar_ready,
  output logic [ADDR_W-1:0]         ar_araddr,
  output logic [7:0]                ar_arlen,
  input  logic                      r_valid,
  input  logic [DATA_W-1:0]         r_rdata,
  input  logic                      r_rlast,
  output logic                      aw_valid,
  input  logic                      aw_ready,
  output logic [ADDR_W-1:0]         aw_awaddr,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic [DATA_W-1:0]         w_wdata,
  output logic [7:0]                w_wstrb,
  output logic                      w_wlast,
  input  logic                      b_valid
);

  localparam int                CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [63:0]       MASK64    = line_addr_mask(BEATS);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MASK64);

  state_t            state, next;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              buf_load, buf_wr, cnt_clr, cnt_inc;
  logic              timeout;

`ifdef AXI_LINE_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  logic            busy;
  logic            err_q;

  assign busy    = state inside {S_AR, S_R, S_AW, S_W, S_B};
  assign timeout = busy && (wd == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on every state change so it measures a single stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      if (!busy || next != state) wd <= '0;
      else                        wd <= wd + WD_W'(1);
      if (timeout)                             err_q <= 1'b1;
      else if (state == S_RESP && resp_ready)  err_q <= 1'b0;
    end
  end

  assign resp_err = err_q;
`else
  assign timeout  = 1'b0;
  // Always 0: the watchdog is compiled out, so its limit never applies.
  assign resp_err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next       = state;
    req_ready  = 1'b0;
    ar_valid   = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    resp_valid = 1'b0;
    buf_load   = 1'b0;
    buf_wr     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          buf_load = req_wen;
          cnt_clr  = 1'b1;
          next     = req_wen ? S_AW : S_AR;
        end
      end
      S_AR: begin
        ar_valid = 1'b1;
        if (ar_ready) next = S_R;
      end
      S_R: begin
        if (r_valid) begin
          buf_wr  = 1'b1;
          cnt_inc = 1'b1;
          // Whichever of rlast or the beat count comes first ends the burst.
          if (r_rlast || cnt == LAST_BEAT) next = S_RESP;
        end
      end
      S_AW: begin
        aw_valid = 1'b1;
        if (aw_ready) next = S_W;
      end
      S_W: begin
        w_valid = 1'b1;
        if (w_ready) begin
          cnt_inc = 1'b1;
          if (cnt == LAST_BEAT) next = S_B;
        end
      end
      S_B: begin
        if (b_valid) next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
    if (timeout) next = S_RESP;
  end

  always_ff @(posedge clock) begin
    if (reset)        cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (state == S_IDLE && req_valid) addr_q <= req_addr & ADDR_MASK;
  end

  axi_line_buffer #(
    .BEATS  (BEATS),
    .DATA_W (DATA_W),
    .IDX_W  (CNT_W)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .load      (buf_load),
    .load_data (req_wdata),
    .wr_en     (buf_wr),
    .wr_idx    (cnt),
    .wr_data   (r_rdata),
    .rd_idx    (cnt),
    .rd_data   (w_wdata),
    .line      (resp_rdata)
  );

  assign ar_araddr = addr_q;
  assign aw_awaddr = addr_q;
  assign ar_arlen  = 8'(BEATS - 1);
  assign w_wstrb   = W_STRB_ALL;
  // wlast is only ever seen on the final beat; the slave answers on it alone.
  assign w_wlast   = w_valid && (cnt == LAST_BEAT);

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master: reads, writes, stalls, reset abort,
// and the watchdog when AXI_LINE_MASTER_TIMEOUT_EN is defined.
module tb_axi_line_master;

  localparam int BEATS  = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int LINE_W = BEATS * DATA_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0, req_wen = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LINE_W-1:0] req_wdata = '0;
  logic              resp_valid, resp_err;
  logic              resp_ready = 1'b0;
  logic [LINE_W-1:0] resp_rdata;
  logic              ar_valid, aw_valid, w_valid, w_wlast;
  logic              ar_ready = 1'b0, aw_ready = 1'b0, w_ready = 1'b0;
  logic [ADDR_W-1:0] ar_araddr, aw_awaddr;
  logic [7:0]        ar_arlen, w_wstrb;
  logic              r_valid = 1'b0, r_rlast = 1'b0, b_valid = 1'b0;
  logic [DATA_W-1:0] r_rdata = '0;
  logic [DATA_W-1:0] w_wdata;

  int checks = 0;
  int failures = 0;

  axi_line_master #(
    .BEATS(BEATS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_araddr(ar_araddr), .ar_arlen(ar_arlen),
    .r_valid(r_valid), .r_rdata(r_rdata), .r_rlast(r_rlast),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_awaddr(aw_awaddr),
    .w_valid(w_valid), .w_ready(w_ready), .w_wdata(w_wdata),
    .w_wstrb(w_wstrb), .w_wlast(w_wlast),
    .b_valid(b_valid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [LINE_W-1:0] wline, exp_line;
  int n, lasts;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_aw_valid", aw_valid, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_w_wlast", w_wlast, 0);
    reset = 1'b0;
    tick();

    // Read 0x8000_0010, beats 0x11..0x44, rlast on the 4th
    req_valid = 1; req_wen = 0; req_addr = 64'h8000_0010;
    chk("rd1_req_ready", req_ready, 1);
    tick(); req_valid = 0;
    chk("rd1_ar_valid", ar_valid, 1);
    chk("rd1_araddr", ar_araddr, 64'h8000_0000);
    chk("rd1_arlen", ar_arlen, 3);
    chk("rd1_req_ready_busy", req_ready, 0);
    ar_ready = 1; tick(); ar_ready = 0;
    chk("rd1_ar_drop", ar_valid, 0);
    for (int i = 0; i < 4; i++) begin
      r_valid = 1; r_rdata = 64'(i + 1) * 64'h11; r_rlast = (i == 3);
      if (i == 3) chk("rd1_resp_early", resp_valid, 0);
      tick();
    end
    r_valid = 0; r_rlast = 0;
    exp_line = {64'h44, 64'h33, 64'h22, 64'h11};
    chk("rd1_resp_valid", resp_valid, 1);
    chk("rd1_rdata", resp_rdata, exp_line);

    // Hold resp_ready low for 5 cycles
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_rdata", resp_rdata, exp_line);
      chk("stall_req_ready", req_ready, 0);
    end
    resp_ready = 1; tick(); resp_ready = 0;
    chk("rd1_resp_done", resp_valid, 0);
    chk("rd1_idle_again", req_ready, 1);

    // Write 0x8000_0058 (aligns to 0x40), w_ready one cycle after AW
    for (int i = 0; i < 4; i++) wline[i*64 +: 64] = 64'hD0D0_0000_0000_0000 + 64'(i);
    req_valid = 1; req_wen = 1; req_addr = 64'h8000_0058; req_wdata = wline;
    tick(); req_valid = 0; req_wen = 0;
    chk("wr1_aw_valid", aw_valid, 1);
    chk("wr1_awaddr", aw_awaddr, 64'h8000_0040);
    chk("wr1_w_valid_in_aw", w_valid, 0);
    chk("wr1_wlast_in_aw", w_wlast, 0);
    b_valid = 1; tick(); b_valid = 0;
    chk("wr1_early_b_ignored", aw_valid, 1);
    aw_ready = 1; tick(); aw_ready = 0;
    chk("wr1_w_valid", w_valid, 1);
    w_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("wr1_wdata", w_wdata, wline[i*64 +: 64]);
      chk("wr1_wlast", w_wlast, (i == 3));
      chk("wr1_wstrb", w_wstrb, 8'hFF);
      tick();
    end
    w_ready = 0;
    chk("wr1_w_done", w_valid, 0);
    chk("wr1_wlast_after", w_wlast, 0);
    chk("wr1_wait_b", resp_valid, 0);
    b_valid = 1; tick(); b_valid = 0;
    chk("wr1_resp_valid", resp_valid, 1);
    chk("wr1_resp_err", resp_err, 0);
    resp_ready = 1; tick(); resp_ready = 0;
    chk("wr1_idle_again", req_ready, 1);

    // Write with w_ready toggling 1,0,1,0
    for (int i = 0; i < 4; i++) wline[i*64 +: 64] = 64'hE000_0000_0000_00A0 + 64'(i);
    req_valid = 1; req_wen = 1; req_addr = 64'h0000_1000; req_wdata = wline;
    tick(); req_valid = 0; req_wen = 0;
    aw_ready = 1; tick(); aw_ready = 0;
    n = 0; lasts = 0;
    for (int c = 0; c < 8; c++) begin
      w_ready = (c % 2 == 0);
      if (w_valid) begin
        chk("wr2_hold_data", w_wdata, wline[n*64 +: 64]);
        chk("wr2_wlast", w_wlast, (n == 3));
        if (w_ready) begin
          if (w_wlast) lasts++;
          n++;
        end
      end
      tick();
    end
    w_ready = 0;
    chk("wr2_beats", n, 4);
    chk("wr2_wlast_count", lasts, 1);
    chk("wr2_w_done", w_valid, 0);
    b_valid = 1; tick(); b_valid = 0;
    chk("wr2_resp_valid", resp_valid, 1);
    resp_ready = 1; tick(); resp_ready = 0;

    // Reset during R at beat 2
    req_valid = 1; req_addr = 64'h0000_3000;
    tick(); req_valid = 0;
    ar_ready = 1; tick(); ar_ready = 0;
    r_valid = 1; r_rdata = 64'hA1; tick();
    r_rdata = 64'hA2; tick();
    r_rdata = 64'hA3; reset = 1; tick();
    reset = 0; r_valid = 0;
    chk("rstmid_ar_valid", ar_valid, 0);
    chk("rstmid_aw_valid", aw_valid, 0);
    chk("rstmid_w_valid", w_valid, 0);
    chk("rstmid_resp_valid", resp_valid, 0);
    chk("rstmid_req_ready", req_ready, 1);

    // New read; no rlast, so the beat count ends the burst
    req_valid = 1; req_addr = 64'h0000_2018;
    tick(); req_valid = 0;
    chk("rd3_araddr", ar_araddr, 64'h0000_2000);
    ar_ready = 1; tick(); ar_ready = 0;
    for (int i = 0; i < 4; i++) begin
      r_valid = 1; r_rdata = 64'hB1 + 64'(i); r_rlast = 0;
      tick();
    end
    r_valid = 0;
    chk("rd3_resp_valid", resp_valid, 1);
    chk("rd3_rdata", resp_rdata, {64'hB4, 64'hB3, 64'hB2, 64'hB1});
    resp_ready = 1; tick(); resp_ready = 0;

    // Early rlast on beat 2; r_valid during AR is ignored
    req_valid = 1; req_addr = 64'h0000_4000;
    tick(); req_valid = 0;
    r_valid = 1; r_rdata = 64'hDEAD; tick();
    chk("rd4_still_ar", ar_valid, 1);
    r_valid = 0; ar_ready = 1; tick(); ar_ready = 0;
    r_valid = 1; r_rdata = 64'hC1; r_rlast = 0; tick();
    r_rdata = 64'hC2; r_rlast = 1; tick();
    r_valid = 0; r_rlast = 0;
    chk("rd4_resp_valid", resp_valid, 1);
    chk("rd4_rdata", resp_rdata, {64'hB4, 64'hB3, 64'hC2, 64'hC1});
    resp_ready = 1; tick(); resp_ready = 0;
    chk("rd4_idle_again", req_ready, 1);

`ifdef AXI_LINE_MASTER_TIMEOUT_EN
    // ar_ready never comes: watchdog fires after 16 cycles in AR
    req_valid = 1; req_addr = 64'h0000_5000;
    tick(); req_valid = 0;
    for (int k = 0; k < 15; k++) tick();
    chk("to_still_ar", ar_valid, 1);
    chk("to_no_resp_yet", resp_valid, 0);
    tick();
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_err", resp_err, 1);
    chk("to_ar_dropped", ar_valid, 0);
    resp_ready = 1; tick(); resp_ready = 0;
    chk("to_err_cleared", resp_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
